// File: rtl/m_cache_refill.sv
// Miss/refill engine: fetches 4-word lines over a single-word req/ack bus and forwards stores.
// Build option CACHE_CRITICAL_WORD_FIRST_EN: fetch the missing word first and return it early.
//   state | meaning
//   IDLE  | wait for a store or a miss
//   STORE | write-through store on the memory bus
//   FETCH | reading the four line words
//   FILL  | one-cycle cache install strobe
//   HOLD  | dead cycle while cache tags catch up
module m_cache_refill #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_miss,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  i_st,
  input  logic [ADDR_WIDTH-1:0] i_st_addr,
  input  logic [31:0]           i_st_data,
  output logic                  o_st_ack,
  output logic                  o_busy,
  output logic                  o_bwe,
  output logic [ADDR_WIDTH-1:0] o_baddr,
  output logic [127:0]          o_bdata,
  output logic                  o_cword_v,
  output logic [31:0]           o_cword,
  output logic                  o_mreq,
  output logic                  o_mwe,
  output logic [ADDR_WIDTH-1:0] o_maddr,
  output logic [31:0]           o_mwdata,
  input  logic                  i_mack,
  input  logic [31:0]           i_mrdata
);

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_FETCH, S_FILL, S_HOLD} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   line_q, line_d;
  logic [1:0]              crit_q, crit_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [3:0][31:0]        buf_q, buf_d;
  logic [1:0]              word_cur, word_nxt, word_first;
  logic                    ack;
  logic                    st_take;

  logic                    busy_d, bwe_d, cword_v_d, st_ack_d, mreq_d, mwe_d;
  logic [ADDR_WIDTH-1:0]   baddr_d, maddr_d;
  logic [127:0]            bdata_d;
  logic [31:0]             cword_d, mwdata_d;

  logic                    unused_miss_lsb;
  assign unused_miss_lsb = ^i_miss_addr[1:0];

  assign ack = o_mreq & i_mack;
  // o_st_ack is high in the first IDLE cycle while the requester still holds i_st
  assign st_take = i_st & ~o_st_ack;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign word_cur   = crit_q + cnt_q;
  assign word_first = i_miss_addr[3:2];
`else
  assign word_cur   = cnt_q;
  assign word_first = 2'd0;
`endif
  assign word_nxt = word_cur + 2'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      line_q    <= '0;
      crit_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      o_busy    <= 1'b0;
      o_bwe     <= 1'b0;
      o_cword_v <= 1'b0;
      o_st_ack  <= 1'b0;
      o_mreq    <= 1'b0;
      o_mwe     <= 1'b0;
      o_baddr   <= '0;
      o_maddr   <= '0;
      o_mwdata  <= '0;
      o_bdata   <= '0;
      o_cword   <= '0;
    end else begin
      state     <= state_nxt;
      line_q    <= line_d;
      crit_q    <= crit_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      o_busy    <= busy_d;
      o_bwe     <= bwe_d;
      o_cword_v <= cword_v_d;
      o_st_ack  <= st_ack_d;
      o_mreq    <= mreq_d;
      o_mwe     <= mwe_d;
      o_baddr   <= baddr_d;
      o_maddr   <= maddr_d;
      o_mwdata  <= mwdata_d;
      o_bdata   <= bdata_d;
      o_cword   <= cword_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (st_take)     state_nxt = S_STORE;
        else if (i_miss) state_nxt = S_FETCH;
      end
      S_STORE: if (ack) state_nxt = S_IDLE;
      S_FETCH: if (ack && cnt_q == 2'd3) state_nxt = S_FILL;
      S_FILL:  state_nxt = S_HOLD;
      S_HOLD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    line_d    = line_q;
    crit_d    = crit_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    busy_d    = (state_nxt != S_IDLE);
    bwe_d     = 1'b0;
    cword_v_d = 1'b0;
    st_ack_d  = 1'b0;
    mreq_d    = o_mreq;
    mwe_d     = o_mwe;
    baddr_d   = o_baddr;
    maddr_d   = o_maddr;
    mwdata_d  = o_mwdata;
    bdata_d   = o_bdata;
    cword_d   = o_cword;
    case (state)
      S_IDLE: begin
        if (st_take) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = i_st_addr;
          mwdata_d = i_st_data;
        end else if (i_miss) begin
          line_d  = {i_miss_addr[ADDR_WIDTH-1:4], 4'b0000};
          crit_d  = i_miss_addr[3:2];
          cnt_d   = 2'd0;
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = {i_miss_addr[ADDR_WIDTH-1:4], word_first, 2'b00};
        end
      end
      S_STORE: begin
        if (ack) begin
          mreq_d   = 1'b0;
          mwe_d    = 1'b0;
          st_ack_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (ack) begin
          buf_d[word_cur] = i_mrdata;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
          if (cnt_q == 2'd0) begin
            cword_v_d = 1'b1;
            cword_d   = i_mrdata;
          end
`endif
          if (cnt_q == 2'd3) begin
            mreq_d  = 1'b0;
            bwe_d   = 1'b1;
            baddr_d = line_q;
            bdata_d = buf_d;
`ifndef CACHE_CRITICAL_WORD_FIRST_EN
            cword_v_d = 1'b1;
            cword_d   = buf_d[crit_q];
`endif
          end else begin
            cnt_d   = cnt_q + 2'd1;
            maddr_d = {line_q[ADDR_WIDTH-1:4], word_nxt, 2'b00};
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m_cache_refill.sv
// Directed bench for m_cache_refill: reset, refills with wait states, stores, abort, early word.
// Expectations follow CACHE_CRITICAL_WORD_FIRST_EN when the bench is built with it.
module tb_m_cache_refill;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_miss;
  logic [31:0]  i_miss_addr;
  logic         i_st;
  logic [31:0]  i_st_addr;
  logic [31:0]  i_st_data;
  logic         o_st_ack;
  logic         o_busy;
  logic         o_bwe;
  logic [31:0]  o_baddr;
  logic [127:0] o_bdata;
  logic         o_cword_v;
  logic [31:0]  o_cword;
  logic         o_mreq;
  logic         o_mwe;
  logic [31:0]  o_maddr;
  logic [31:0]  o_mwdata;
  logic         i_mack;
  logic [31:0]  i_mrdata;

  m_cache_refill #(.ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_st(i_st), .i_st_addr(i_st_addr), .i_st_data(i_st_data), .o_st_ack(o_st_ack),
    .o_busy(o_busy), .o_bwe(o_bwe), .o_baddr(o_baddr), .o_bdata(o_bdata),
    .o_cword_v(o_cword_v), .o_cword(o_cword),
    .o_mreq(o_mreq), .o_mwe(o_mwe), .o_maddr(o_maddr), .o_mwdata(o_mwdata),
    .i_mack(i_mack), .i_mrdata(i_mrdata)
  );

  localparam logic [127:0] LINE_1230 = 128'h000000A3_000000A2_000000A1_000000A0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [64];
  int          wait_n = 0;
  int          wcnt = 0;
  logic        force_mack = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] p_addr, p_wd;
  logic        p_we;
  int          stab_err = 0;

  int cyc = 0;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] wd_q[$];
  int bwe_n, cword_n, st_ack_n, mwe_cyc_n;
  int first_req_cyc, first_ack_cyc, last_ack_cyc, wr_ack_cyc;
  int bwe_cyc, cword_cyc, st_ack_cyc;
  logic [31:0]  cap_baddr, cap_cword;
  logic [127:0] cap_bdata;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr_logs();
    rd_q.delete(); wr_q.delete(); wd_q.delete();
    bwe_n = 0; cword_n = 0; st_ack_n = 0; mwe_cyc_n = 0;
    first_req_cyc = -1; first_ack_cyc = -1; last_ack_cyc = -1; wr_ack_cyc = -1;
    bwe_cyc = -1; cword_cyc = -1; st_ack_cyc = -1;
  endtask

  // one clock: memory model responds to the registered request, then outputs are logged
  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    if (prev_pend && (!o_mreq || o_maddr !== p_addr || o_mwe !== p_we || o_mwdata !== p_wd))
      stab_err++;
    if (o_mreq) begin
      if (first_req_cyc < 0 && !o_mwe) first_req_cyc = cyc;
      if (o_mwe) mwe_cyc_n++;
      if (wcnt >= wait_n) begin
        i_mack = 1'b1; wcnt = 0; prev_pend = 1'b0;
        if (o_mwe) begin
          mem[o_maddr[7:2]] = o_mwdata;
          wr_q.push_back(o_maddr); wd_q.push_back(o_mwdata);
          wr_ack_cyc = cyc;
          i_mrdata = 32'hBAD0_BAD0;
        end else begin
          i_mrdata = mem[o_maddr[7:2]];
          rd_q.push_back(o_maddr);
          if (first_ack_cyc < 0) first_ack_cyc = cyc;
          last_ack_cyc = cyc;
        end
      end else begin
        i_mack = 1'b0; wcnt++; prev_pend = 1'b1;
        p_addr = o_maddr; p_we = o_mwe; p_wd = o_mwdata;
        i_mrdata = 32'h0;
      end
    end else begin
      i_mack = force_mack; i_mrdata = 32'hFFFF_FFFF; wcnt = 0; prev_pend = 1'b0;
    end
    if (o_bwe) begin bwe_n++; bwe_cyc = cyc; cap_baddr = o_baddr; cap_bdata = o_bdata; end
    if (o_cword_v) begin cword_n++; cword_cyc = cyc; cap_cword = o_cword; end
    if (o_st_ack) begin st_ack_n++; st_ack_cyc = cyc; end
  endtask

  task automatic do_refill(input logic [31:0] addr, input int waits,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3,
                           input logic [31:0] exp_cw, input string tag);
    int t;
    int miss_cyc;
    logic [31:0] exp_rd [4];
    exp_rd[0] = e0; exp_rd[1] = e1; exp_rd[2] = e2; exp_rd[3] = e3;
    clr_logs();
    wait_n = waits;
    i_miss = 1'b1; i_miss_addr = addr; miss_cyc = cyc;
    t = 0;
    while (bwe_n == 0 && t < 200) begin tick(); t++; end
    chk_eq({tag, "_bwe_seen"}, bwe_n, 1);
    tick();
    chk_eq({tag, "_hold_busy"}, o_busy, 1'b1);
    i_miss = 1'b0;
    repeat (4) tick();
    chk_eq({tag, "_nreads"}, rd_q.size(), 4);
    for (int k = 0; k < 4; k++)
      chk_eq({tag, "_rdaddr"}, (k < rd_q.size()) ? rd_q[k] : 32'hxxxx_xxxx, exp_rd[k]);
    chk_eq({tag, "_bwe_once"}, bwe_n, 1);
    chk_eq({tag, "_baddr"}, cap_baddr, 32'h0000_1230);
    chk_eq({tag, "_bdata"}, cap_bdata, LINE_1230);
    chk_eq({tag, "_cword_once"}, cword_n, 1);
    chk_eq({tag, "_cword"}, cap_cword, exp_cw);
    chk_eq({tag, "_first_req_lat"}, first_req_cyc, miss_cyc + 1);
    chk_eq({tag, "_bwe_lat"}, bwe_cyc, last_ack_cyc + 1);
    chk_eq({tag, "_refill_len"}, bwe_cyc, miss_cyc + 1 + 4 * (waits + 1));
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    chk_eq({tag, "_cword_cyc"}, cword_cyc, first_ack_cyc + 1);
`else
    chk_eq({tag, "_cword_cyc"}, cword_cyc, bwe_cyc);
`endif
    chk_eq({tag, "_idle_busy"}, o_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic busy_at_ack;
    for (int k = 0; k < 64; k++) mem[k] = 32'hA0 + (k % 4);
    clr_logs();
    i_rst_n = 1'b0; i_mack = 1'b0; i_mrdata = '0;
    i_miss = 1'b1; i_miss_addr = 32'h1234;
    i_st = 1'b1; i_st_addr = 32'h40; i_st_data = 32'h1111_2222;

    // T1 reset with both requests asserted
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_eq("t1_mreq_in_reset", o_mreq, 1'b0);
    end
    chk_eq("t1_flags", {o_busy, o_bwe, o_cword_v, o_st_ack, o_mreq, o_mwe}, 6'b0);
    chk_eq("t1_addrs", {o_baddr, o_maddr, o_mwdata, o_cword}, 128'h0);
    chk_eq("t1_bdata", o_bdata, 128'h0);
    i_miss = 1'b0; i_st = 1'b0;
    i_rst_n = 1'b1;
    tick();

    // T2 miss 0x1234 with 2 wait states
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    do_refill(32'h1234, 2, 32'h1234, 32'h1238, 32'h123C, 32'h1230, 32'hA1, "t2");
`else
    do_refill(32'h1234, 2, 32'h1230, 32'h1234, 32'h1238, 32'h123C, 32'hA1, "t2");
`endif

    // T3 store with 2 wait states
    clr_logs();
    wait_n = 2;
    i_st = 1'b1; i_st_addr = 32'h40; i_st_data = 32'hDEAD_BEEF;
    t = 0;
    while (st_ack_n == 0 && t < 50) begin tick(); t++; end
    busy_at_ack = o_busy;
    i_st = 1'b0;
    chk_eq("t3_st_ack_seen", st_ack_n, 1);
    chk_eq("t3_busy_at_ack", busy_at_ack, 1'b0);
    repeat (3) tick();
    chk_eq("t3_nwrites", wr_q.size(), 1);
    chk_eq("t3_waddr", (wr_q.size() > 0) ? wr_q[0] : 32'hx, 32'h40);
    chk_eq("t3_wdata", (wd_q.size() > 0) ? wd_q[0] : 32'hx, 32'hDEAD_BEEF);
    chk_eq("t3_mwe_cycles", mwe_cyc_n, 3);
    chk_eq("t3_st_ack_once", st_ack_n, 1);
    chk_eq("t3_ack_lat", st_ack_cyc, wr_ack_cyc + 1);
    chk_eq("t3_no_reads", rd_q.size(), 0);

    // T4 store and miss to the same line in the same cycle
    clr_logs();
    wait_n = 0;
    i_st = 1'b1; i_st_addr = 32'h1230; i_st_data = 32'h55;
    i_miss = 1'b1; i_miss_addr = 32'h1230;
    t = 0;
    while (bwe_n == 0 && t < 100) begin
      tick(); t++;
      if (o_st_ack) i_st = 1'b0;
    end
    tick();
    i_miss = 1'b0;
    repeat (4) tick();
    chk_eq("t4_nwrites", wr_q.size(), 1);
    chk_eq("t4_waddr", (wr_q.size() > 0) ? wr_q[0] : 32'hx, 32'h1230);
    chk_eq("t4_store_first", (wr_ack_cyc >= 0) && (wr_ack_cyc < first_ack_cyc), 1'b1);
    chk_eq("t4_nreads", rd_q.size(), 4);
    chk_eq("t4_bwe_once", bwe_n, 1);
    chk_eq("t4_bdata", cap_bdata, 128'h000000A3_000000A2_000000A1_00000055);
    mem[12] = 32'hA0;

    // T5 reset after two fetch acks, then a clean refetch
    clr_logs();
    wait_n = 0;
    i_miss = 1'b1; i_miss_addr = 32'h1234;
    t = 0;
    while (rd_q.size() < 2 && t < 50) begin tick(); t++; end
    chk_eq("t5_two_acks", rd_q.size(), 2);
    i_rst_n = 1'b0; i_miss = 1'b0;
    tick();
    chk_eq("t5_mreq_after_rst", o_mreq, 1'b0);
    chk_eq("t5_busy_after_rst", o_busy, 1'b0);
    tick();
    i_rst_n = 1'b1;
    repeat (5) tick();
    chk_eq("t5_no_bwe", bwe_n, 0);
    chk_eq("t5_no_more_reads", rd_q.size(), 2);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    do_refill(32'h1234, 1, 32'h1234, 32'h1238, 32'h123C, 32'h1230, 32'hA1, "t5r");
`else
    do_refill(32'h1234, 1, 32'h1230, 32'h1234, 32'h1238, 32'h123C, 32'hA1, "t5r");
`endif

    // stray ack with no request outstanding
    clr_logs();
    force_mack = 1'b1;
    repeat (3) tick();
    force_mack = 1'b0;
    tick();
    chk_eq("stray_ack_quiet", {o_busy, o_mreq, o_bwe, o_st_ack, o_cword_v}, 5'b0);
    chk_eq("stray_ack_no_events", bwe_n + st_ack_n + cword_n, 0);

    // T6 miss on word 2, zero wait
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    do_refill(32'h1238, 0, 32'h1238, 32'h123C, 32'h1230, 32'h1234, 32'hA2, "t6");
`else
    do_refill(32'h1238, 0, 32'h1230, 32'h1234, 32'h1238, 32'h123C, 32'hA2, "t6");
`endif

    chk_eq("bus_stable", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
